// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry result FIFO that serialises 64-bit RZ values
// into 32-bit beats (two beats for MUL/DIV results, one beat otherwise).
module alu_result_stage #(
  parameter logic [4:0] MUL_CODE = 5'b00010,
  parameter logic [4:0] DIV_CODE = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [63:0] in_rz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_hi,
  output logic        out_last,
  output logic [1:0]  count
);

  typedef struct packed {
    logic [4:0]  op;
    logic [63:0] rz;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     head;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       hi_q, hi_d;
  logic [1:0] cnt_q, cnt_d;
  logic       two_beat;
  logic       push, pop, hs;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign count     = cnt_q;

  assign head     = mem_q[rd_ptr_q];
  assign two_beat = (head.op == MUL_CODE) || (head.op == DIV_CODE);

  always_comb begin
    out_data = 32'h0;
    out_hi   = 1'b0;
    out_last = 1'b0;
    if (out_valid) begin
      out_hi   = hi_q;
      out_last = hi_q | ~two_beat;
      out_data = hi_q ? head.rz[63:32] : head.rz[31:0];
    end
  end

  assign push = in_valid & in_ready;
  assign hs   = out_valid & out_ready;
  assign pop  = hs & out_last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (hs)   hi_d     = ~out_last;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      hi_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is left unreset; only occupancy decides what is visible.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_opcode, in_rz};
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed steps plus random traffic,
// checked against a beat scoreboard and an occupancy model.
module tb_alu_result_stage;

  localparam logic [4:0] MUL = 5'b00010;
  localparam logic [4:0] DIV = 5'b00011;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic [63:0] in_rz = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_hi;
  logic        out_last;
  logic [1:0]  count;

  alu_result_stage #(.MUL_CODE(MUL), .DIV_CODE(DIV)) dut (
    .clock(clock), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rz(in_rz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hi(out_hi),
    .out_last(out_last), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic        hi;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    tb_cnt = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    armed = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled mid-cycle; inputs change 1 time unit after posedge.
  always @(negedge clock) begin
    beat_t b;
    bit    ev, rdy;
    if (armed) begin
      ev  = (tb_cnt != 0);
      rdy = (tb_cnt != 2);
      check("in_ready", in_ready, rdy);
      check("count", count, tb_cnt);
      check("out_valid", out_valid, ev);
      if (ev && sb.size() > 0) begin
        b = sb[0];
        check("out_data", out_data, b.d);
        check("out_hi", out_hi, b.hi);
        check("out_last", out_last, b.last);
      end else begin
        check("idle_data", out_data, 0);
        check("idle_hi", out_hi, 0);
        check("idle_last", out_last, 0);
      end
      if (clear) begin
        sb.delete();
        tb_cnt = 0;
      end else begin
        if (ev && out_ready && sb.size() > 0) begin
          b = sb.pop_front();
          if (b.last) tb_cnt--;
        end
        if (in_valid && rdy) begin
          tb_cnt++;
          if (in_opcode == MUL || in_opcode == DIV) begin
            sb.push_back('{in_rz[31:0], 1'b0, 1'b0});
            sb.push_back('{in_rz[63:32], 1'b1, 1'b1});
          end else begin
            sb.push_back('{in_rz[31:0], 1'b0, 1'b1});
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] op,
                       input logic [63:0] rz, input logic rdy);
    in_valid  = v;
    in_opcode = op;
    in_rz     = rz;
    out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && tb_cnt != 0; i++) begin
      @(posedge clock);
      #1;
    end
    check(tag, (tb_cnt == 0), 1);
  endtask

  initial begin
    clear = 1'b1;
    @(posedge clock);
    armed = 1;
    #1;
    @(posedge clock);
    #1;
    clear = 1'b0;

    // single add
    drive(1, 5'b00000, 64'h0000_0000_0000_0007, 1);
    drive(0, 0, 0, 1);
    drain("add_drain");

    // mul, two beats
    drive(1, MUL, 64'h1234_5678_9ABC_DEF0, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drain("mul_drain");

    // full: third push rejected
    drive(1, 5'b00100, 64'h1111_1111_AAAA_0001, 0);
    drive(1, 5'b00101, 64'h2222_2222_AAAA_0002, 0);
    drive(1, 5'b00110, 64'h3333_3333_AAAA_0003, 0);
    check("full_count", count, 2);
    check("full_in_ready", in_ready, 0);
    drive(0, 0, 0, 0);
    drain("full_drain");

    // stall: div at head, out_ready toggling
    drive(1, DIV, 64'hCAFE_F00D_DEAD_BEEF, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, i[0]);
    drain("stall_drain");

    // simultaneous push/pop at count=1, across pointer wraps
    drive(1, 5'b01000, 64'h0000_0000_0000_0100, 1);
    for (int i = 1; i < 7; i++)
      drive(1, 5'b01000, 64'h0000_0000_0000_0100 + 64'(i), 1);
    check("pp_count", count, 1);
    drain("pp_drain");

    // clear mid two-beat delivery
    drive(1, MUL, 64'h8765_4321_0FED_CBA9, 1);
    drive(0, 0, 0, 1);
    clear = 1'b1;
    drive(0, 0, 0, 1);
    clear = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_data", out_data, 0);
    check("clr_in_ready", in_ready, 1);
    check("clr_count", count, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      int r;
      r  = $urandom_range(0, 3);
      op = (r == 0) ? MUL : (r == 1) ? DIV : 5'($urandom_range(0, 31));
      clear = ($urandom_range(0, 59) == 0);
      drive(1'($urandom_range(0, 1)), op, {$urandom, $urandom},
            1'($urandom_range(0, 1)));
    end
    clear = 1'b0;
    drain("rand_drain");

    @(posedge clock);
    #1;
    armed = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter MUL_CODE, default 5'b00010, opcode whose 64-bit result is delivered as two beats.
REQ-002 Parameter DIV_CODE, default 5'b00011, opcode whose 64-bit result is delivered as two beats.
REQ-003 Port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 Port clear  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 Port in_valid  input  1  ALU result and opcode presented this cycle.
REQ-006 Port in_ready  output  1  stage can accept a result this cycle.
REQ-007 Port in_opcode  input  5  opcode that produced in_rz.
REQ-008 Port in_rz  input  64  ALU RZ value; bits [31:0] form ZLo, bits [63:32] form ZHi.
REQ-009 Port out_valid  output  1  a beat is available on out_data.
REQ-010 Port out_ready  input  1  consumer accepts the current beat.
REQ-011 Port out_data  output  32  current beat: ZLo or ZHi of head entry.
REQ-012 Port out_hi  output  1  1 = out_data carries ZHi, 0 = ZLo.
REQ-013 Port out_last  output  1  current beat is the final beat of the head entry.
REQ-014 Port count  output  2  buffered entries, 0..2.

Function
REQ-015 Stage SHALL hold a 2-entry FIFO of {opcode, rz} with write pointer, read pointer and occupancy count.
REQ-016 in_ready SHALL equal (count != 2), combinationally from registered state only.
REQ-017 Push SHALL occur on a rising edge where in_valid && in_ready; in_rz and in_opcode written at write pointer, write pointer toggles.
REQ-018 No bypass: a pushed entry SHALL first appear on out_data the cycle after the push edge (1-cycle latency).
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 Head entry with opcode == MUL_CODE or DIV_CODE SHALL be delivered as two beats: ZLo (out_hi=0, out_last=0) then ZHi (out_hi=1, out_last=1).
REQ-021 Any other opcode SHALL be delivered as one beat: ZLo with out_hi=0, out_last=1; ZHi discarded.
REQ-022 Beat phase register hi_phase SHALL set on a handshake (out_valid && out_ready) of a non-last beat and clear on a handshake of a last beat.
REQ-023 Pop SHALL occur on a handshake where out_last=1; read pointer toggles, hi_phase clears.
REQ-024 Simultaneous push and pop in one cycle SHALL leave count unchanged; both pointers advance.
REQ-025 Push without pop SHALL increment count; pop without push SHALL decrement count; count SHALL never exceed 2 or underflow.
REQ-026 in_valid while in_ready=0 SHALL be ignored; no FIFO state changes.
REQ-027 out_ready while out_valid=0 SHALL be ignored; hi_phase unchanged.
REQ-028 While out_valid=0, out_data SHALL be 32'h0, out_hi=0, out_last=0.
REQ-029 Beat data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-030 Pointers SHALL wrap 1 -> 0.

Reset
REQ-031 clear=1 at a rising edge SHALL set count=0, both pointers=0, hi_phase=0; hence out_valid=0, out_data=0, out_hi=0, out_last=0, in_ready=1 the following cycle.
REQ-032 clear SHALL take priority over simultaneous push, pop or beat advance, including mid two-beat delivery; partially delivered entry is discarded.
REQ-033 Stored FIFO data need not be cleared.

Verification
REQ-034 Single add: push opcode 5'b00000, in_rz=64'h0000_0000_0000_0007, out_ready=1 -> next cycle one beat out_data=32'h7, out_hi=0, out_last=1; count returns to 0.
REQ-035 Mul: push opcode MUL_CODE, in_rz=64'h1234_5678_9ABC_DEF0, out_ready=1 -> beats 32'h9ABC_DEF0 (out_hi=0) then 32'h1234_5678 (out_hi=1, out_last=1).
REQ-036 Full: out_ready=0, push three results back-to-back -> first two accepted, count=2, in_ready=0 on third; third not stored.
REQ-037 Stall: div result at head, out_ready toggles 0/1 each cycle -> each beat held until accepted, ZLo then ZHi, no duplicates.
REQ-038 Simultaneous push/pop at count=1 -> count stays 1, order preserved across pointer wrap.
REQ-039 clear asserted after ZLo beat of a mul accepted -> next cycle count=0, out_valid=0, out_data=0, in_ready=1.
